// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side controller for fifo_sync.
// Pops words from the FIFO and re-times its registered data_out into a
// valid/ready stream through a 2-entry skid buffer, so backpressure never
// costs throughput. m_last marks every BURST_LEN-th beat.
// Optional feature: define FIFO_RD_WORDCNT_EN to add the 32-bit words_out
// beat counter port.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
`ifdef FIFO_RD_WORDCNT_EN
  ,
  output logic [31:0]           words_out
`endif
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [1:0]            occ;
  logic                  infl;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [CW-1:0]         beat_cnt;
  logic                  beat;
  logic                  pop;
  logic [2:0]            level;
  logic [1:0]            slot;

  // Occupancy bookkeeping: level is what occ becomes after this edge, and
  // slot is where an arriving word lands once the head has been consumed.
  // The pop rule keeps level + new in-flight at most 2, so the buffer never
  // overflows even though m_ready feeds the pop strobe combinationally.
  always_comb begin
    beat  = m_valid && m_ready;
    level = {1'b0, occ} + {2'b00, infl} - {2'b00, beat};
    slot  = occ - {1'b0, beat};
    pop   = (state == RUN) && !fifo_empty && (level < 3'd2);
  end

  assign fifo_rd_en = pop;
  assign fifo_cs    = pop;
  assign m_valid    = (occ != 2'd0);
  assign m_data     = head_q;
  assign m_last     = m_valid && (beat_cnt == LAST_BEAT);
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: DRAIN delivers whatever is buffered or in flight
  // without popping; re-enabling returns to RUN with nothing lost.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) state_next = RUN;
      end
      RUN: begin
        if (!enable) state_next = ((occ != 2'd0) || infl) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (enable) state_next = RUN;
        else if ((occ == 2'd0) && !infl) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Skid buffer: a beat shifts the tail into the head, and the word popped
  // last cycle is captured into the first free slot after that shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= 2'd0;
      infl   <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ  <= level[1:0];
      infl <= pop;
      if (beat) head_q <= tail_q;
      if (infl) begin
        if (slot == 2'd0) head_q <= fifo_data;
        else tail_q <= fifo_data;
      end
    end
  end

  // Burst beat counter; only reset clears it so bursts span enable toggles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (beat) begin
      if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
      else beat_cnt <= beat_cnt + CW'(1);
    end
  end

`ifdef FIFO_RD_WORDCNT_EN
  // Total beat count, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_out <= 32'd0;
    end else if (beat) begin
      words_out <= words_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: bench for fifo_rd_stream with a behavioural fifo_sync
// model and a scoreboard of words loaded into that FIFO. Define
// FIFO_RD_WORDCNT_EN to exercise the words_out counter as well.
module tb_fifo_rd_stream;

  localparam int DW = 32;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_cs;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
`ifdef FIFO_RD_WORDCNT_EN
  logic [31:0]   words_out;
`endif

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_cs    (fifo_cs),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
`ifdef FIFO_RD_WORDCNT_EN
    ,
    .words_out  (words_out)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  int            rd_ptr = 0;
  int            wr_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // fifo_sync model: registered data_out one cycle after a pop.
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr % 256];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic        en;
    logic        rdy;
    logic        rd_en;
    logic        valid;
    logic        busy;
    logic [31:0] data;
  } vec_t;

  vec_t          vecs [7];
  logic [DW-1:0] exp_q [$];
  int            total = 0;
  int            bad = 0;
  int            pop_count = 0;
  int            beat_count = 0;
  int            outstanding = 0;
  int            beat_idx = 0;
  int            beats_since_reset = 0;
  logic [15:0]   last_hist = '0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [DW-1:0] w);
    mem[wr_ptr % 256] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  task automatic sample_outputs();
    logic [DW-1:0] w;
    @(negedge clk);
    if (rst_n) begin
      if (prev_hold) begin
        check_bit("hold_valid", m_valid, 1'b1);
        check_output("hold_data", m_data, prev_data);
      end
      if (fifo_rd_en) begin
        pop_count++;
        outstanding++;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_beat: got 0x%0h, want no beat", m_data);
        end else begin
          w = exp_q.pop_front();
          check_output("beat_data", m_data, w);
          check_bit("beat_last", m_last, beat_idx == BL - 1);
        end
        if (beats_since_reset < 16) last_hist[beats_since_reset] = m_last;
        beat_idx = (beat_idx + 1) % BL;
        outstanding--;
        beat_count++;
        beats_since_reset++;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  endtask

  task automatic tick();
    sample_outputs();
    advance();
  endtask

  // Asserts reset mid-cycle, drops words the DUT held, then releases.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_bit("rst_valid", m_valid, 1'b0);
    check_output("rst_data", m_data, 32'h0);
    check_bit("rst_last", m_last, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_rd_en", fifo_rd_en, 1'b0);
`ifdef FIFO_RD_WORDCNT_EN
    check_output("rst_words_out", words_out, 32'd0);
`endif
    for (int i = 0; i < outstanding; i++) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    outstanding = 0;
    beat_idx = 0;
    beats_since_reset = 0;
    last_hist = '0;
    prev_hold = 1'b0;
    advance();
    advance();
    rst_n = 1'b1;
  endtask

  task automatic drain_all(input string name, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 40) begin
      tick();
      cycles++;
    end
    check_output({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int pb;
    int bb;
    int cyc;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA000_0001};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB000_0002};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hC000_0003};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};

    rst_n   = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b0;
    advance();
    advance();
    check_bit("init_valid", m_valid, 1'b0);
    check_output("init_data", m_data, 32'h0);
    check_bit("init_last", m_last, 1'b0);
    check_bit("init_busy", busy, 1'b0);
    check_bit("init_rd_en", fifo_rd_en, 1'b0);

    // Three words, streaming consumer: cycle-by-cycle table.
    load_word(32'hA000_0001);
    load_word(32'hB000_0002);
    load_word(32'hC000_0003);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      enable  = vecs[i].en;
      m_ready = vecs[i].rdy;
      sample_outputs();
      check_bit($sformatf("v%0d_rd_en", i), fifo_rd_en, vecs[i].rd_en);
      check_bit($sformatf("v%0d_cs", i), fifo_cs, vecs[i].rd_en);
      check_bit($sformatf("v%0d_valid", i), m_valid, vecs[i].valid);
      check_bit($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      if (vecs[i].valid) check_output($sformatf("v%0d_data", i), m_data, vecs[i].data);
      advance();
    end

    // Backpressure: only two pops while stalled, then full-rate drain.
    m_ready = 1'b0;
    pb = pop_count;
    for (int i = 0; i < 10; i++) load_word(32'h2000_0000 + 32'(i));
    repeat (6) tick();
    check_output("stall_pops", pop_count - pb, 32'd2);
    check_bit("stall_valid", m_valid, 1'b1);
    check_output("stall_data", m_data, 32'h2000_0000);
    check_bit("stall_last", m_last, beat_idx == BL - 1);
    m_ready = 1'b1;
    drain_all("stall", cyc);
    check_output("stall_cycles", cyc, 32'd10);

    // Burst boundaries: nine beats from a fresh counter.
    enable  = 1'b0;
    m_ready = 1'b0;
    apply_reset();
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++) load_word(32'h3000_0000 + 32'(i));
    drain_all("burst", cyc);
    check_output("burst_beats", beats_since_reset, 32'd9);
    check_output("burst_last_pattern", {23'b0, last_hist[8:0]}, 32'h0000_0088);

    // Enable dropped with a full buffer: drain without further pops.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) load_word(32'h4000_0000 + 32'(i));
    repeat (5) tick();
    enable = 1'b0;
    pb = pop_count;
    repeat (4) tick();
    check_output("drain_pops", pop_count - pb, 32'd0);
    check_bit("drain_busy", busy, 1'b1);
    check_bit("drain_valid", m_valid, 1'b1);
    m_ready = 1'b1;
    bb = beat_count;
    cyc = 0;
    while (busy && cyc < 10) begin
      tick();
      cyc++;
    end
    check_output("drain_beats", beat_count - bb, 32'd2);
    check_bit("drain_idle_busy", busy, 1'b0);
    check_bit("drain_idle_valid", m_valid, 1'b0);

    // Reset mid-stream with one word buffered and one in flight.
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) load_word(32'h5000_0000 + 32'(i));
    repeat (4) tick();
    check_output("midrst_outstanding", outstanding, 32'd2);
    apply_reset();
    check_output("midrst_next_word", exp_q[0], 32'h5000_0002);
    drain_all("midrst", cyc);
    check_bit("midrst_fifo_empty", fifo_empty, 1'b1);

`ifdef FIFO_RD_WORDCNT_EN
    // Word counter after five beats since reset, then cleared by reset.
    load_word(32'h6000_0000);
    drain_all("wcnt", cyc);
    check_output("wcnt_five", words_out, 32'd5);
    enable = 1'b0;
    apply_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
